// File: rtl/gpr_dump_unit_pkg.sv
// Shared definitions for the GPR dump unit: FSM encoding, width defaults, signature reset value.
// Optional feature macro: GPR_DUMP_SIGNATURE_EN.
package gpr_dump_unit_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Every signature bit starts from this value.
  localparam logic SIG_RESET_BIT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_SIG  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/gpr_dump_unit_signature.sv
// Rotate-left-by-one then XOR accumulator over the dumped register words.
// Instantiated only when GPR_DUMP_SIGNATURE_EN is defined.
module gpr_dump_signature
  import gpr_dump_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_sig_next
);

  logic [DATA_W-1:0] r_sig;

  // The next value is exported so the final word can be emitted on the last handshake.
  assign o_sig_next = {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ i_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sig <= {DATA_W{SIG_RESET_BIT}};
    end else if (i_clr) begin
      r_sig <= {DATA_W{SIG_RESET_BIT}};
    end else if (i_en) begin
      r_sig <= o_sig_next;
    end
  end

endmodule

// File: rtl/gpr_dump_unit.sv
// Walks registers FIRST_REG..LAST_REG through a read port and streams each value out.
// Defining GPR_DUMP_SIGNATURE_EN appends a rotate-xor signature word after the last register.
module gpr_dump_unit
  import gpr_dump_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [2:0]        dbg_state
);

  // Stream contract: a word transfers on a cycle with out_valid & out_ready high; while
  // out_valid is high and out_ready low, out_data/out_index/out_last hold and out_valid stays up.

  localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(LAST_REG);
`ifdef GPR_DUMP_SIGNATURE_EN
  localparam logic LP_SIG_EN = 1'b1;
`else
  localparam logic LP_SIG_EN = 1'b0;
`endif

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_last;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_data;

  logic w_hs;
  logic w_at_last;

  assign w_hs      = r_valid & out_ready;
  assign w_at_last = (r_idx == LP_LAST);

`ifdef GPR_DUMP_SIGNATURE_EN
  logic [DATA_W-1:0] w_sig_next;
  logic              w_sig_clr;
  logic              w_sig_en;

  assign w_sig_clr = (r_state == ST_IDLE) && start;
  assign w_sig_en  = (r_state == ST_SEND) && w_hs;

  gpr_dump_signature #(.DATA_W(DATA_W)) u_sig (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_sig_clr),
    .i_en      (w_sig_en),
    .i_word    (r_data),
    .o_sig_next(w_sig_next)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_index <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= LP_FIRST;
            r_busy  <= 1'b1;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_data  <= rf_rdata;
          r_index <= r_idx;
          r_last  <= w_at_last && !LP_SIG_EN;
          r_valid <= 1'b1;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            // Compare before incrementing so LAST_REG at the top of the address range never wraps.
            if (!w_at_last) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_READ;
            end else begin
`ifdef GPR_DUMP_SIGNATURE_EN
              r_data  <= w_sig_next;
              r_index <= '0;
              r_last  <= 1'b1;
              r_valid <= 1'b1;
              r_state <= ST_SIG;
`else
              r_done  <= 1'b1;
              r_state <= ST_DONE;
`endif
            end
          end
        end
`ifdef GPR_DUMP_SIGNATURE_EN
        ST_SIG: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rf_addr   = r_idx;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_index = r_index;
  assign out_last  = r_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gpr_dump_unit.sv
// Bench for gpr_dump_unit: a full-range instance and a single-register instance, each fed by
// a register-file array and checked against a queue built from the register contents.
module tb_gpr_dump_unit;
  import gpr_dump_unit_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = AW + 1 + DW;
`ifdef GPR_DUMP_SIGNATURE_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start_a, ready_a, busy_a, done_a, valid_a, last_a;
  logic [AW-1:0] addr_a, index_a;
  logic [DW-1:0] rdata_a, data_a;
  logic [2:0]    dbg_a;
  logic [DW-1:0] regs_a [32];

  logic          start_b, ready_b, busy_b, done_b, valid_b, last_b;
  logic [AW-1:0] addr_b, index_b;
  logic [DW-1:0] rdata_b, data_b;
  logic [2:0]    dbg_b;
  logic [DW-1:0] regs_b [32];

  assign rdata_a = regs_a[addr_a];
  assign rdata_b = regs_b[addr_b];

  logic [PW-1:0] obs_a, obs_b;
  assign obs_a = {index_a, last_a, data_a};
  assign obs_b = {index_b, last_b, data_b};

  gpr_dump_unit u_dut (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .rf_addr(addr_a), .rf_rdata(rdata_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_data(data_a), .out_index(index_a), .out_last(last_a), .dbg_state(dbg_a)
  );

  gpr_dump_unit #(.FIRST_REG(5), .LAST_REG(5)) u_one (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .rf_addr(addr_b), .rf_rdata(rdata_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_b), .out_index(index_b), .out_last(last_b), .dbg_state(dbg_b)
  );

  // ---------------- checking ----------------
  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] exp_a[$];
  logic [PW-1:0] exp_b[$];
  int done_a_cnt = 0;
  int done_b_cnt = 0;

  function automatic logic [PW-1:0] pkt(input int idx, input bit last, input logic [DW-1:0] data);
    return {AW'(idx), last, data};
  endfunction

  // Expected stream: one word per register in order, then the signature word when enabled.
  task automatic build_model(input int which, input int first, input int last);
    logic [DW-1:0] sig;
    logic [DW-1:0] w;
    logic [PW-1:0] p;
    sig = '0;
    for (int i = first; i <= last; i++) begin
      w = (which == 0) ? regs_a[i] : regs_b[i];
      p = pkt(i, !SIG_ON && (i == last), w);
      if (which == 0) exp_a.push_back(p); else exp_b.push_back(p);
      sig = ((sig << 1) | (sig >> (DW - 1))) ^ w;
    end
    if (SIG_ON) begin
      p = pkt(0, 1'b1, sig);
      if (which == 0) exp_a.push_back(p); else exp_b.push_back(p);
    end
  endtask

  // ---------------- monitors / scoreboard ----------------
  logic          stall_a;
  logic [PW-1:0] held_a;
  initial begin
    stall_a = 1'b0;
    held_a  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_a = 1'b0;
      end else begin
        if (stall_a) begin
          check("a_valid_held", 64'(valid_a), 64'd1);
          check("a_word_held", 64'(obs_a), 64'(held_a));
        end
        if (valid_a && ready_a) begin
          if (exp_a.size() == 0) check("a_extra_word", 64'(exp_a.size()), 64'd1);
          else check("a_word", 64'(obs_a), 64'(exp_a.pop_front()));
        end
        stall_a = valid_a && !ready_a;
        held_a  = obs_a;
        if (done_a) done_a_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (valid_b && ready_b) begin
          if (exp_b.size() == 0) check("b_extra_word", 64'(exp_b.size()), 64'd1);
          else check("b_word", 64'(obs_b), 64'(exp_b.pop_front()));
        end
        if (done_b) done_b_cnt++;
      end
    end
  end

  // Consumer back-pressure: random 0/1 per cycle when enabled.
  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready_a = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    int n;
    n = 0;
    while ((((which == 0) ? done_a : done_b) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((which == 0) ? "a_done_seen" : "b_done_seen",
          64'((which == 0) ? done_a : done_b), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_word_a(input int idx, input int budget);
    int n;
    n = 0;
    while (!(valid_a && index_a == AW'(idx)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_word_reached", 64'(index_a), 64'(idx));
  endtask

  task automatic end_of_dump_a(input string tag);
    check({tag, "_queue_drained"}, 64'(exp_a.size()), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_a_cnt), 64'd1);
    check({tag, "_busy_low"}, 64'(busy_a), 64'd0);
    check({tag, "_idle"}, 64'(dbg_a), 64'(ST_IDLE));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_done"}, 64'(done_a), 64'd0);
    check({tag, "_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_last"}, 64'(last_a), 64'd0);
    check({tag, "_data"}, 64'(data_a), 64'd0);
    check({tag, "_index"}, 64'(index_a), 64'd0);
    check({tag, "_rf_addr"}, 64'(addr_a), 64'd0);
    check({tag, "_state"}, 64'(dbg_a), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  int lat;
  initial begin
    reset = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = '0;
      regs_b[i] = '0;
    end
    #12;
    check_reset_values("rst");
    check("rst_b_valid", 64'(valid_b), 64'd0);
    check("rst_b_state", 64'(dbg_b), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // All registers equal, consumer always ready; also measures start-to-valid latency.
    for (int i = 1; i < 32; i++) regs_a[i] = 32'hcafebabe;
    build_model(0, 1, 31);
    done_a_cnt = 0;
    @(posedge clk);
    #1 start_a = 1'b1;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      lat++;
      if (valid_a) break;
    end
    check("first_valid_latency", 64'(lat), 64'd2);
    check("busy_during_dump", 64'(busy_a), 64'd1);
    wait_done(0, 200);
    end_of_dump_a("flat");

    // Distinct per-register values under random back-pressure.
    for (int i = 1; i < 32; i++) regs_a[i] = 32'(i) * 32'h01010101;
    build_model(0, 1, 31);
    done_a_cnt = 0;
    rand_ready = 1'b1;
    pulse_start(0);
    wait_done(0, 2000);
    end_of_dump_a("stall");

    // Random register contents, still with back-pressure.
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    build_model(0, 1, 31);
    done_a_cnt = 0;
    pulse_start(0);
    wait_done(0, 2000);
    rand_ready = 1'b0;
    ready_a = 1'b1;
    end_of_dump_a("rand");

    // Single-register instance.
    regs_b[5] = 32'h00000008;
    build_model(1, 5, 5);
    done_b_cnt = 0;
    pulse_start(1);
    wait_done(1, 50);
    check("one_queue_drained", 64'(exp_b.size()), 64'd0);
    check("one_done_pulses", 64'(done_b_cnt), 64'd1);
    check("one_busy_low", 64'(busy_b), 64'd0);

    // Asynchronous reset while word 10 is being presented, then a fresh full dump.
    for (int i = 1; i < 32; i++) regs_a[i] = $urandom;
    build_model(0, 1, 31);
    done_a_cnt = 0;
    pulse_start(0);
    wait_word_a(10, 100);
    #2 reset = 1'b0;
    #1;
    check_reset_values("abort");
    exp_a.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_a_cnt), 64'd0);
    #2 reset = 1'b1;
    build_model(0, 1, 31);
    done_a_cnt = 0;
    pulse_start(0);
    wait_done(0, 200);
    end_of_dump_a("restart");

    // A second start during the dump must be ignored.
    build_model(0, 1, 31);
    done_a_cnt = 0;
    pulse_start(0);
    wait_word_a(3, 100);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done(0, 200);
    repeat (6) @(negedge clk);
    end_of_dump_a("restart_ignored");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
